ddr_lane_delay_seq: RTL and testbench

- Parametrised sequencer for the delay-line controls of NUM_LANES DDR PHY lane controllers.
- Accepts delay-line MOVE or LOAD commands over a valid/ready handshake and issues single-cycle MOVE/LOAD pulses with a programmable inter-step gap.
- Wraps each operation in a per-lane HS_IO_CLK_PAUSE window with configurable pre/post extension.
- Aborts a move on delay-line out-of-range. Sits between the training logic and the lane-control macro wrappers, in the FAB_CLK domain.

---
 rtl/ddr_phy_pkg.sv | 21 ++
 rtl/ddr_lane_phase_timer.sv | 27 ++
 rtl/ddr_lane_delay_seq.sv | 174 +++++++++++++++++
 tb/tb_ddr_lane_delay_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_phy_pkg.sv
// Shared types and helpers for the DDR lane delay-line sequencer.
package ddr_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PULSE,
        ST_GAP,
        ST_POST,
        ST_DONE
    } state_e;

    localparam logic SEL_RX = 1'b0;
    localparam logic SEL_TX = 1'b1;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_lane_phase_timer.sv
// Loadable down-counter; terminal is high once the count reaches zero.
module ddr_lane_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             fab_clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fab_clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/ddr_lane_delay_seq.sv
// Sequences delay-line MOVE/LOAD pulses for one selected lane, wrapped in an
// optional HS_IO_CLK_PAUSE window, with abort on delay-line out-of-range.
module ddr_lane_delay_seq
    import ddr_phy_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int STEP_W     = 8,
    parameter bit PAUSE_EN   = 1'b1,
    parameter int PAUSE_PRE  = 2,
    parameter int PAUSE_POST = 2,
    parameter int MOVE_GAP   = 3,
    localparam int LANE_W    = clog2_min1(NUM_LANES)
) (
    input  logic                 FAB_CLK,
    input  logic                 RESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [LANE_W-1:0]    CMD_LANE,
    input  logic                 CMD_LOAD,
    input  logic                 CMD_DIRECTION,
    input  logic                 CMD_SEL,
    input  logic [STEP_W-1:0]    CMD_STEPS,
    input  logic [NUM_LANES-1:0] RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic [NUM_LANES-1:0] TX_DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_SEL,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [STEP_W-1:0]    DONE_STEPS,
    output logic                 DONE_ERR
);

    localparam bit PRE_ON  = PAUSE_EN && (PAUSE_PRE > 0);
    localparam bit POST_ON = PAUSE_EN && (PAUSE_POST > 0);
    localparam int MAX_PP  = (PAUSE_PRE > PAUSE_POST) ? PAUSE_PRE : PAUSE_POST;
    localparam int MAX_DUR = (MAX_PP > MOVE_GAP) ? MAX_PP : MOVE_GAP;
    localparam int CNT_W   = clog2_min1(MAX_DUR);

    // Phase lengths are loaded as length-1 so the terminal flag marks the last cycle.
    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'((PAUSE_PRE  > 0) ? PAUSE_PRE  - 1 : 0);
    localparam logic [CNT_W-1:0] POST_LD = CNT_W'((PAUSE_POST > 0) ? PAUSE_POST - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((MOVE_GAP   > 0) ? MOVE_GAP   - 1 : 0);
    localparam state_e AFTER_OPS = POST_ON ? ST_POST : ST_DONE;

    state_e              state, state_nxt;
    logic [LANE_W-1:0]   lane_q;
    logic                load_q, dir_q, sel_q, err_q;
    logic [STEP_W-1:0]   steps_q, step_cnt;
    logic [STEP_W-1:0]   done_steps_q;
    logic                done_err_q;

    logic                accept, cmd_lane_ok, set_err, oor;
    logic                tmr_load, tmr_done;
    logic [CNT_W-1:0]    tmr_val;

    assign accept      = (state == ST_IDLE) && CMD_VALID;
    assign cmd_lane_ok = 32'(CMD_LANE) < 32'(NUM_LANES);

    ddr_lane_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .fab_clk  (FAB_CLK),
        .reset    (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .terminal (tmr_done)
    );

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    if (!cmd_lane_ok)                   state_nxt = ST_DONE;
                    else if (PRE_ON)                    state_nxt = ST_PRE;
                    else if (!CMD_LOAD && CMD_STEPS == '0) state_nxt = AFTER_OPS;
                    else                                state_nxt = ST_PULSE;
                end
            end
            ST_PRE: begin
                if (tmr_done) state_nxt = (!load_q && steps_q == '0) ? AFTER_OPS : ST_PULSE;
            end
            ST_PULSE: state_nxt = ST_GAP;
            ST_GAP: begin
                if (tmr_done) begin
                    if (oor) begin
                        set_err   = 1'b1;
                        state_nxt = AFTER_OPS;
                    end else if (load_q || step_cnt == steps_q) begin
                        state_nxt = AFTER_OPS;
                    end else begin
                        state_nxt = ST_PULSE;
                    end
                end
            end
            ST_POST: if (tmr_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Every timed phase is entered through a state change, so that is the load point.
        tmr_load = (state_nxt != state);
        case (state_nxt)
            ST_PRE:  tmr_val = PRE_LD;
            ST_GAP:  tmr_val = GAP_LD;
            ST_POST: tmr_val = POST_LD;
            default: tmr_val = '0;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            lane_q       <= '0;
            load_q       <= 1'b0;
            dir_q        <= 1'b0;
            sel_q        <= 1'b0;
            steps_q      <= '0;
            step_cnt     <= '0;
            err_q        <= 1'b0;
            done_steps_q <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lane_q   <= CMD_LANE;
                load_q   <= CMD_LOAD;
                dir_q    <= CMD_DIRECTION;
                sel_q    <= CMD_SEL;
                steps_q  <= CMD_STEPS;
                step_cnt <= '0;
                err_q    <= !cmd_lane_ok;
            end
            if (state == ST_PULSE) step_cnt <= step_cnt + STEP_W'(1);
            if (set_err)           err_q    <= 1'b1;
            if (state_nxt == ST_DONE && state != ST_DONE) begin
                done_steps_q <= accept ? '0 : step_cnt;
                done_err_q   <= accept ? !cmd_lane_ok : (err_q | set_err);
            end
        end
    end

    always_comb begin
        DELAY_LINE_MOVE      = '0;
        DELAY_LINE_LOAD      = '0;
        DELAY_LINE_DIRECTION = '0;
        DELAY_LINE_SEL       = '0;
        HS_IO_CLK_PAUSE      = '0;
        oor                  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LANE_W'(i) == lane_q) begin
                DELAY_LINE_MOVE[i]      = (state == ST_PULSE) && !load_q;
                DELAY_LINE_LOAD[i]      = (state == ST_PULSE) && load_q;
                DELAY_LINE_DIRECTION[i] = (state != ST_IDLE) && dir_q;
                DELAY_LINE_SEL[i]       = (state != ST_IDLE) && sel_q;
                HS_IO_CLK_PAUSE[i]      = PAUSE_EN && (state inside {ST_PRE, ST_PULSE, ST_GAP, ST_POST});
                if (sel_q == SEL_TX)      oor = TX_DELAY_LINE_OUT_OF_RANGE[i];
                else if (sel_q == SEL_RX) oor = RX_DELAY_LINE_OUT_OF_RANGE[i];
            end
        end
    end

    assign CMD_READY  = (state == ST_IDLE);
    assign BUSY       = (state != ST_IDLE);
    assign DONE       = (state == ST_DONE);
    assign DONE_STEPS = done_steps_q;
    assign DONE_ERR   = done_err_q;

endmodule

// File: tb/tb_ddr_lane_delay_seq.sv
// Bench for ddr_lane_delay_seq: a default instance and a 3-lane, pause-disabled
// instance, both checked cycle by cycle against a timeline model built from the phase rules.
module tb_ddr_lane_delay_seq;

    localparam int GAP  = 3;
    localparam int PRE  = 2;
    localparam int POST = 2;

    logic       clk, rst;
    logic       drv_valid, drv_load, drv_dir, drv_sel;
    logic [1:0] drv_lane;
    logic [7:0] drv_steps;
    logic [3:0] drv_rx, drv_tx;
    int         which;

    logic       a_valid, a_ready, a_busy, a_done, a_err;
    logic [0:0] a_lane;
    logic [1:0] a_rx, a_tx, a_move, a_load, a_dir, a_sel, a_pause;
    logic [7:0] a_steps;

    logic       b_valid, b_ready, b_busy, b_done, b_err;
    logic [1:0] b_lane;
    logic [2:0] b_rx, b_tx, b_move, b_load, b_dir, b_sel, b_pause;
    logic [7:0] b_steps;

    logic       obs_ready, obs_busy, obs_done, obs_err;
    logic [3:0] obs_pause, obs_move, obs_load, obs_dir, obs_sel;
    logic [7:0] obs_steps;
    logic [22:0] obs_vec;

    int n_pass = 0;
    int n_total = 0;

    assign a_valid = (which == 0) && drv_valid;
    assign b_valid = (which == 1) && drv_valid;
    assign a_lane  = drv_lane[0:0];
    assign b_lane  = drv_lane;
    assign a_rx    = drv_rx[1:0];
    assign a_tx    = drv_tx[1:0];
    assign b_rx    = drv_rx[2:0];
    assign b_tx    = drv_tx[2:0];

    ddr_lane_delay_seq dut_a (
        .FAB_CLK(clk), .RESET(rst), .CMD_VALID(a_valid), .CMD_READY(a_ready),
        .CMD_LANE(a_lane), .CMD_LOAD(drv_load), .CMD_DIRECTION(drv_dir), .CMD_SEL(drv_sel),
        .CMD_STEPS(drv_steps), .RX_DELAY_LINE_OUT_OF_RANGE(a_rx), .TX_DELAY_LINE_OUT_OF_RANGE(a_tx),
        .DELAY_LINE_MOVE(a_move), .DELAY_LINE_LOAD(a_load), .DELAY_LINE_DIRECTION(a_dir),
        .DELAY_LINE_SEL(a_sel), .HS_IO_CLK_PAUSE(a_pause), .BUSY(a_busy), .DONE(a_done),
        .DONE_STEPS(a_steps), .DONE_ERR(a_err)
    );

    ddr_lane_delay_seq #(.NUM_LANES(3), .PAUSE_EN(1'b0)) dut_b (
        .FAB_CLK(clk), .RESET(rst), .CMD_VALID(b_valid), .CMD_READY(b_ready),
        .CMD_LANE(b_lane), .CMD_LOAD(drv_load), .CMD_DIRECTION(drv_dir), .CMD_SEL(drv_sel),
        .CMD_STEPS(drv_steps), .RX_DELAY_LINE_OUT_OF_RANGE(b_rx), .TX_DELAY_LINE_OUT_OF_RANGE(b_tx),
        .DELAY_LINE_MOVE(b_move), .DELAY_LINE_LOAD(b_load), .DELAY_LINE_DIRECTION(b_dir),
        .DELAY_LINE_SEL(b_sel), .HS_IO_CLK_PAUSE(b_pause), .BUSY(b_busy), .DONE(b_done),
        .DONE_STEPS(b_steps), .DONE_ERR(b_err)
    );

    always_comb begin
        if (which == 0) begin
            obs_ready = a_ready; obs_busy = a_busy; obs_done = a_done; obs_err = a_err;
            obs_steps = a_steps;
            obs_pause = {2'b00, a_pause}; obs_move = {2'b00, a_move}; obs_load = {2'b00, a_load};
            obs_dir   = {2'b00, a_dir};   obs_sel  = {2'b00, a_sel};
        end else begin
            obs_ready = b_ready; obs_busy = b_busy; obs_done = b_done; obs_err = b_err;
            obs_steps = b_steps;
            obs_pause = {1'b0, b_pause}; obs_move = {1'b0, b_move}; obs_load = {1'b0, b_load};
            obs_dir   = {1'b0, b_dir};   obs_sel  = {1'b0, b_sel};
        end
        obs_vec = {obs_ready, obs_busy, obs_done, obs_pause, obs_move, obs_load, obs_dir, obs_sel};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the out-of-range inputs for cycle k: the watched lane/line follows the
    // [on, off) window, every other bit is random noise the DUT must ignore.
    task automatic drive_oor(input int k, input bit lane_ok, input int lane, input bit sel,
                             input int on, input int off);
        drv_rx = 4'($urandom);
        drv_tx = 4'($urandom);
        if (lane_ok) begin
            if (sel) drv_tx[lane] = (k >= on) && (k < off);
            else     drv_rx[lane] = (k >= on) && (k < off);
        end
    endtask

    // Issues one command at c0 and compares every output each cycle until the
    // block is idle again (or one cycle after an injected reset).
    task automatic run_cmd(input int w, input int lane, input bit ld, input bit dir, input bit sel,
                           input int steps, input int on, input int off, input int rst_req,
                           output int done_seen, output int pulses_seen, output int steps_seen,
                           output bit err_seen);
        int nl, pre, post, first, n, d, p, end_k, rst_at;
        bit pe, lane_ok, err, pulse_k;
        logic [3:0] mask;
        logic [22:0] exp_vec;

        nl = (w == 0) ? 2 : 3;
        pe = (w == 0);
        lane_ok = lane < nl;
        pre = pe ? PRE : 0;
        post = pe ? POST : 0;
        first = 1 + pre;
        n = 0;
        err = 0;
        if (!lane_ok) begin
            err = 1;
            d = 1;
        end else if (!ld && steps == 0) begin
            d = first + post;
        end else begin
            p = first;
            for (int j = 0; j < 300; j++) begin
                n++;
                if (p + GAP >= on && p + GAP < off) begin
                    err = 1;
                    break;
                end
                if (ld || n == steps) break;
                p += GAP + 1;
            end
            d = p + GAP + 1 + post;
        end
        mask = lane_ok ? 4'(1 << lane) : 4'b0000;
        rst_at = (rst_req >= 1 && rst_req < d) ? rst_req : -1;
        end_k = (rst_at >= 0) ? rst_at + 1 : d + 1;
        done_seen = -1;
        pulses_seen = 0;
        steps_seen = -1;
        err_seen = 0;

        @(posedge clk); #1;
        which = w;
        drv_rst_set(1'b0);
        drv_valid = 1'b1;
        drv_lane = 2'(lane);
        drv_load = ld;
        drv_dir = dir;
        drv_sel = sel;
        drv_steps = 8'(steps);
        drive_oor(0, lane_ok, lane, sel, on, off);
        @(negedge clk);
        n_total++;
        if (obs_ready !== 1'b1 || obs_busy !== 1'b0)
            $display("FAIL c0_ready w%0d: ready=%b busy=%b, required ready=1 busy=0", w, obs_ready, obs_busy);
        else n_pass++;

        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            drv_rst_set(k == rst_at);
            drv_valid = (k < end_k) ? 1'($urandom) : 1'b0;
            drv_lane = 2'($urandom);
            drv_load = 1'($urandom);
            drv_dir = 1'($urandom);
            drv_sel = 1'($urandom);
            drv_steps = 8'($urandom);
            drive_oor(k, lane_ok, lane, sel, on, off);
            @(negedge clk);
            pulse_k = (n > 0) && (k >= first) && ((k - first) % (GAP + 1) == 0)
                      && ((k - first) / (GAP + 1) < n);
            if (k == end_k)
                exp_vec = {1'b1, 22'b0};
            else
                exp_vec = {1'b0, 1'b1, (k == d),
                           (pe && k < d) ? mask : 4'b0000,
                           (pulse_k && !ld) ? mask : 4'b0000,
                           (pulse_k && ld) ? mask : 4'b0000,
                           dir ? mask : 4'b0000,
                           sel ? mask : 4'b0000};
            n_total++;
            if (obs_vec !== exp_vec)
                $display("FAIL outputs w%0d c%0d: got %h, required %h (rdy,busy,done,pause,move,load,dir,sel)",
                         w, k, obs_vec, exp_vec);
            else n_pass++;
            if (obs_done === 1'b1 && done_seen < 0) begin
                done_seen = k;
                steps_seen = int'(obs_steps);
                err_seen = obs_err;
            end
            if (((obs_move | obs_load) & mask) != 4'b0000) pulses_seen++;
            if (k == d && k < end_k) begin
                n_total++;
                if (obs_steps !== 8'(n) || obs_err !== err)
                    $display("FAIL done_result w%0d c%0d: steps=%0d err=%b, required steps=%0d err=%b",
                             w, k, obs_steps, obs_err, n, err);
                else n_pass++;
            end
            if (k == end_k && rst_at >= 0) begin
                n_total++;
                if (obs_steps !== 8'd0 || obs_err !== 1'b0)
                    $display("FAIL reset_result w%0d c%0d: steps=%0d err=%b, required 0/0",
                             w, k, obs_steps, obs_err);
                else n_pass++;
            end
        end
        drv_rst_set(1'b0);
    endtask

    task automatic drv_rst_set(input bit v);
        rst = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            which = w;
            @(negedge clk);
            n_total++;
            if (obs_vec !== {1'b1, 22'b0} || obs_steps !== 8'd0 || obs_err !== 1'b0)
                $display("FAIL reset_state w%0d: vec=%h steps=%0d err=%b, required vec=%h steps=0 err=0",
                         w, obs_vec, obs_steps, obs_err, {1'b1, 22'b0});
            else n_pass++;
        end
    endtask

    task automatic test_move_basic();
        int dc, pc, sc;
        bit er;
        run_cmd(0, 1, 1'b0, 1'b1, 1'b0, 3, -1, -1, -1, dc, pc, sc, er);
        n_total++;
        if (dc !== 17 || pc !== 3 || sc !== 3 || er !== 1'b0)
            $display("FAIL move_basic: done@%0d pulses=%0d steps=%0d err=%b, required 17/3/3/0", dc, pc, sc, er);
        else n_pass++;
    endtask

    task automatic test_load();
        int dc, pc, sc;
        bit er;
        run_cmd(0, 0, 1'b1, 1'b0, 1'b1, 7, -1, -1, -1, dc, pc, sc, er);
        n_total++;
        if (dc !== 9 || pc !== 1 || sc !== 1 || er !== 1'b0)
            $display("FAIL load: done@%0d pulses=%0d steps=%0d err=%b, required 9/1/1/0", dc, pc, sc, er);
        else n_pass++;
    endtask

    task automatic test_oor_abort();
        int dc, pc, sc;
        bit er;
        // Raised just after the c6 sample point, so the c10 GAP end is the first to see it.
        run_cmd(0, 0, 1'b0, 1'b0, 1'b0, 10, 7, 1000, -1, dc, pc, sc, er);
        n_total++;
        if (dc !== 13 || pc !== 2 || sc !== 2 || er !== 1'b1)
            $display("FAIL oor_abort: done@%0d pulses=%0d steps=%0d err=%b, required 13/2/2/1", dc, pc, sc, er);
        else n_pass++;
    endtask

    task automatic test_invalid_lane();
        int dc, pc, sc;
        bit er;
        run_cmd(1, 3, 1'b0, 1'b1, 1'b1, 5, -1, -1, -1, dc, pc, sc, er);
        n_total++;
        if (dc !== 1 || pc !== 0 || sc !== 0 || er !== 1'b1)
            $display("FAIL invalid_lane: done@%0d pulses=%0d steps=%0d err=%b, required 1/0/0/1", dc, pc, sc, er);
        else n_pass++;
    endtask

    task automatic test_no_pause_zero_steps();
        int dc, pc, sc;
        bit er;
        run_cmd(1, 0, 1'b0, 1'b1, 1'b0, 0, -1, -1, -1, dc, pc, sc, er);
        n_total++;
        if (dc !== 1 || pc !== 0 || sc !== 0 || er !== 1'b0)
            $display("FAIL zero_steps: done@%0d pulses=%0d steps=%0d err=%b, required 1/0/0/0", dc, pc, sc, er);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int dc, pc, sc;
        bit er;
        run_cmd(0, 1, 1'b0, 1'b1, 1'b1, 5, -1, -1, 8, dc, pc, sc, er);
        n_total++;
        if (dc !== -1 || pc !== 2)
            $display("FAIL reset_mid_op: done@%0d pulses=%0d, required no DONE and 2 pulses", dc, pc);
        else n_pass++;
        run_cmd(0, 0, 1'b0, 1'b0, 1'b1, 2, -1, -1, -1, dc, pc, sc, er);
        n_total++;
        if (dc !== 13 || sc !== 2 || er !== 1'b0)
            $display("FAIL after_reset: done@%0d steps=%0d err=%b, required 13/2/0", dc, sc, er);
        else n_pass++;
    endtask

    task automatic test_max_steps();
        int dc, pc, sc;
        bit er;
        run_cmd(1, 2, 1'b0, 1'b0, 1'b1, 255, -1, -1, -1, dc, pc, sc, er);
        n_total++;
        if (dc !== 1021 || pc !== 255 || sc !== 255 || er !== 1'b0)
            $display("FAIL max_steps: done@%0d pulses=%0d steps=%0d err=%b, required 1021/255/255/0", dc, pc, sc, er);
        else n_pass++;
    endtask

    task automatic test_random();
        int w, lane, steps, on, off, rq, dc, pc, sc;
        bit ld, er;
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(0, 1);
            lane = (w == 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
            ld = ($urandom % 4) == 0;
            steps = $urandom_range(0, 8);
            if ($urandom % 2 == 1) begin
                on = $urandom_range(1, 30);
                off = on + $urandom_range(1, 6);
            end else begin
                on = -1;
                off = -1;
            end
            rq = ($urandom % 5 == 0) ? $urandom_range(1, 30) : -1;
            run_cmd(w, lane, ld, 1'($urandom), 1'($urandom), steps, on, off, rq, dc, pc, sc, er);
        end
    endtask

    initial begin
        which = 0;
        rst = 1'b1;
        drv_valid = 1'b0;
        drv_lane = 2'b00;
        drv_load = 1'b0;
        drv_dir = 1'b0;
        drv_sel = 1'b0;
        drv_steps = 8'd0;
        drv_rx = 4'b0000;
        drv_tx = 4'b0000;
        test_reset();
        test_move_basic();
        test_load();
        test_oor_abort();
        test_invalid_lane();
        test_no_pause_zero_steps();
        test_reset_mid_op();
        test_max_steps();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
